date_counter: RTL and testbench

- BCD calendar register for the Millennium Clock: holds day, month and four-digit year.
- Advances one day per `day_tick` pulse from the time-of-day chain.
- Obtains month length from `day_of_month` instances: one for the running date, one for validating load requests.
- Output digits feed the display mux and the alarm comparator.

---
 rtl/clock_pkg.sv | 40 ++++
 rtl/day_of_month.sv | 45 ++++
 rtl/date_counter.sv | 227 ++++++++++++++++++++++
 tb/tb_date_counter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared BCD types and helpers for the Millennium Clock calendar chain.
// Digits are 4-bit packed BCD; helpers convert and ripple-increment them.
package clock_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    logic co;
    bcd_t d;
  } bcd_inc_t;

  localparam int MONTH_MAX = 12;
  localparam int DAYS_MAX  = 31;

  function automatic logic [6:0] bcd2bin2(
    input bcd_t ten,
    input bcd_t unit
  );
    return 7'(ten) * 7'd10 + 7'(unit);
  endfunction

  function automatic bcd_inc_t bcd_inc(
    input bcd_t d,
    input logic ci
  );
    bcd_inc_t r;
    r.co = 1'b0;
    r.d  = d;
    if (ci) begin
      if (d >= 4'd9) begin
        r.co = 1'b1;
        r.d  = 4'd0;
      end else begin
        r.d = d + 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/day_of_month.sv
// Month length lookup for a BCD month/year with Gregorian leap rule.
// Unknown months return 0 so any day compare against them fails.
module day_of_month
  import clock_pkg::*;
(
  input  logic [7:0]  month,
  input  logic [15:0] year,
  output logic [4:0]  days
);

  logic [6:0] yl;
  logic [6:0] yh;
  logic       leap;
  logic       long_m;
  logic       short_m;
  logic       feb;

  assign yl = bcd2bin2(year[7:4], year[3:0]);
  assign yh = bcd2bin2(year[15:12], year[11:8]);

  // Century years are leap only when the century itself divides by 4
  assign leap = (yl == 7'd0) ? ((yh % 7'd4) == 7'd0)
                             : ((yl % 7'd4) == 7'd0);

  assign long_m = (month == 8'h01) || (month == 8'h03) ||
                  (month == 8'h05) || (month == 8'h07) ||
                  (month == 8'h08) || (month == 8'h10) ||
                  (month == 8'h12);

  assign short_m = (month == 8'h04) || (month == 8'h06) ||
                   (month == 8'h09) || (month == 8'h11);

  assign feb = (month == 8'h02);

  always_comb begin
    days = '0;
    unique case (1'b1)
      long_m:  days = 5'(DAYS_MAX);
      short_m: days = 5'd30;
      feb:     days = leap ? 5'd29 : 5'd28;
      default: days = '0;
    endcase
  end

endmodule

// File: rtl/date_counter.sv
// BCD day/month/year register advanced by day_tick, loadable via set_*.
// Optional weekday tracking is enabled with DATE_COUNTER_WEEKDAY_EN.
module date_counter
  import clock_pkg::*;
#(
  parameter logic [15:0] RST_YEAR  = 16'h2000,
  parameter logic [7:0]  RST_MONTH = 8'h01,
  parameter logic [7:0]  RST_DAY   = 8'h01
`ifdef DATE_COUNTER_WEEKDAY_EN
  ,
  parameter logic [2:0]  RST_WDAY  = 3'd6
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        day_tick,
  input  logic        set_valid,
  input  logic [7:0]  set_day,
  input  logic [7:0]  set_month,
  input  logic [15:0] set_year,
`ifdef DATE_COUNTER_WEEKDAY_EN
  input  logic [2:0]  set_wday,
  output logic [2:0]  wday,
`endif
  output logic        set_err,
  output logic [3:0]  day_unit,
  output logic [3:0]  day_ten,
  output logic [3:0]  month_unit,
  output logic [3:0]  month_ten,
  output logic [3:0]  year_unit,
  output logic [3:0]  year_ten,
  output logic [3:0]  year_hundered,
  output logic [3:0]  year_thousand,
  output logic        month_roll,
  output logic        year_roll,
  output logic        wrap
);

  logic [7:0]  day_q;
  logic [7:0]  day_d;
  logic [7:0]  month_q;
  logic [7:0]  month_d;
  logic [15:0] year_q;
  logic [15:0] year_d;

  logic err_q;
  logic err_d;
  logic mroll_q;
  logic mroll_d;
  logic yroll_q;
  logic yroll_d;
  logic wrap_q;
  logic wrap_d;

  logic [4:0] cur_max;
  logic [4:0] set_max;
  logic [6:0] day_bin;
  logic       last_day;

  logic [31:0] set_all;
  logic [6:0]  set_m_bin;
  logic [6:0]  set_d_bin;
  logic        nib_ok;
  logic        month_ok;
  logic        day_ok;
  logic        wday_ok;
  logic        set_ok;

  bcd_inc_t   di0;
  bcd_inc_t   mi0;
  bcd_inc_t   yi0;
  bcd_inc_t   yi1;
  bcd_inc_t   yi2;
  bcd_inc_t   yi3;
  logic [7:0]  day_inc;
  logic [7:0]  month_inc;
  logic [15:0] year_inc;

  day_of_month u_cur_dom (
    .month (month_q),
    .year  (year_q),
    .days  (cur_max)
  );

  day_of_month u_set_dom (
    .month (set_month),
    .year  (set_year),
    .days  (set_max)
  );

  assign day_bin  = bcd2bin2(day_q[7:4], day_q[3:0]);
  assign last_day = (day_bin == {2'b00, cur_max});

  // Tens digits of day/month never exceed 3 so a plain add cannot overflow
  always_comb begin
    di0       = bcd_inc(day_q[3:0], 1'b1);
    day_inc   = {day_q[7:4] + {3'b000, di0.co}, di0.d};
    mi0       = bcd_inc(month_q[3:0], 1'b1);
    month_inc = {month_q[7:4] + {3'b000, mi0.co}, mi0.d};
    yi0       = bcd_inc(year_q[3:0], 1'b1);
    yi1       = bcd_inc(year_q[7:4], yi0.co);
    yi2       = bcd_inc(year_q[11:8], yi1.co);
    yi3       = bcd_inc(year_q[15:12], yi2.co);
    year_inc  = {yi3.d, yi2.d, yi1.d, yi0.d};
  end

  assign set_all   = {set_day, set_month, set_year};
  assign set_m_bin = bcd2bin2(set_month[7:4], set_month[3:0]);
  assign set_d_bin = bcd2bin2(set_day[7:4], set_day[3:0]);

  always_comb begin
    nib_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (set_all[i*4 +: 4] > 4'd9) begin
        nib_ok = 1'b0;
      end
    end
  end

  assign month_ok = (set_m_bin >= 7'd1) &&
                    (set_m_bin <= 7'(MONTH_MAX));
  assign day_ok   = (set_d_bin >= 7'd1) &&
                    (set_d_bin <= {2'b00, set_max});

`ifdef DATE_COUNTER_WEEKDAY_EN
  assign wday_ok = (set_wday <= 3'd6);
`else
  assign wday_ok = 1'b1;
`endif

  assign set_ok = nib_ok && month_ok && day_ok && wday_ok;

  // A load request always claims the cycle, dropping any coincident tick
  always_comb begin
    day_d   = day_q;
    month_d = month_q;
    year_d  = year_q;
    err_d   = 1'b0;
    mroll_d = 1'b0;
    yroll_d = 1'b0;
    wrap_d  = 1'b0;
    if (set_valid) begin
      if (set_ok) begin
        day_d   = set_day;
        month_d = set_month;
        year_d  = set_year;
      end else begin
        err_d = 1'b1;
      end
    end else if (day_tick) begin
      if (!last_day) begin
        day_d = day_inc;
      end else begin
        day_d   = 8'h01;
        mroll_d = 1'b1;
        if (month_q == 8'h12) begin
          month_d = 8'h01;
          year_d  = year_inc;
          yroll_d = 1'b1;
          wrap_d  = yi3.co;
        end else begin
          month_d = month_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      day_q   <= RST_DAY;
      month_q <= RST_MONTH;
      year_q  <= RST_YEAR;
      err_q   <= 1'b0;
      mroll_q <= 1'b0;
      yroll_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      day_q   <= day_d;
      month_q <= month_d;
      year_q  <= year_d;
      err_q   <= err_d;
      mroll_q <= mroll_d;
      yroll_q <= yroll_d;
      wrap_q  <= wrap_d;
    end
  end

`ifdef DATE_COUNTER_WEEKDAY_EN
  logic [2:0] wday_q;
  logic [2:0] wday_d;

  always_comb begin
    wday_d = wday_q;
    if (set_valid) begin
      if (set_ok) begin
        wday_d = set_wday;
      end
    end else if (day_tick) begin
      wday_d = (wday_q == 3'd6) ? 3'd0 : wday_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wday_q <= RST_WDAY;
    end else begin
      wday_q <= wday_d;
    end
  end

  assign wday = wday_q;
`endif

  assign set_err       = err_q;
  assign month_roll    = mroll_q;
  assign year_roll     = yroll_q;
  assign wrap          = wrap_q;
  assign day_unit      = day_q[3:0];
  assign day_ten       = day_q[7:4];
  assign month_unit    = month_q[3:0];
  assign month_ten     = month_q[7:4];
  assign year_unit     = year_q[3:0];
  assign year_ten      = year_q[7:4];
  assign year_hundered = year_q[11:8];
  assign year_thousand = year_q[15:12];

endmodule

// File: tb/tb_date_counter.sv
// Self-checking bench for date_counter: integer calendar model plus
// directed loads, ticks and rejects with literal expectations.
module tb_date_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        day_tick = 1'b0;
  logic        set_valid = 1'b0;
  logic [7:0]  set_day = '0;
  logic [7:0]  set_month = '0;
  logic [15:0] set_year = '0;
  logic        set_err;
  logic [3:0]  day_unit, day_ten, month_unit, month_ten;
  logic [3:0]  year_unit, year_ten, year_hundered, year_thousand;
  logic        month_roll, year_roll, wrap;
  logic [2:0]  w_in;
`ifdef DATE_COUNTER_WEEKDAY_EN
  logic [2:0]  set_wday = '0;
  logic [2:0]  wday;
  assign w_in = set_wday;
`else
  assign w_in = 3'd0;
`endif

  int tests = 0;
  int fails = 0;
  bit live = 0;

  int md, mm, my, mw;
  bit e_err, e_mr, e_yr, e_wr;

  always #5 clk = ~clk;

  date_counter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .day_tick      (day_tick),
    .set_valid     (set_valid),
    .set_day       (set_day),
    .set_month     (set_month),
    .set_year      (set_year),
`ifdef DATE_COUNTER_WEEKDAY_EN
    .set_wday      (set_wday),
    .wday          (wday),
`endif
    .set_err       (set_err),
    .day_unit      (day_unit),
    .day_ten       (day_ten),
    .month_unit    (month_unit),
    .month_ten     (month_ten),
    .year_unit     (year_unit),
    .year_ten      (year_ten),
    .year_hundered (year_hundered),
    .year_thousand (year_thousand),
    .month_roll    (month_roll),
    .year_roll     (year_roll),
    .wrap          (wrap)
  );

  function automatic bit is_leap(int y);
    return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
  endfunction

  function automatic int days_in(int m, int y);
    if (m == 2) return is_leap(y) ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  function automatic int dec(logic [15:0] v);
    return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 +
           int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] bcd2(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] bcd4(int v);
    return {4'(v / 1000), 4'((v / 100) % 10),
            4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic bit set_ok(logic [7:0] d, logic [7:0] m,
                                logic [15:0] y, logic [2:0] w);
    logic [31:0] all;
    int di, mi, yi;
    all = {d, m, y};
    for (int i = 0; i < 8; i++)
      if (all[i*4 +: 4] > 4'd9) return 0;
    di = dec({8'h00, d});
    mi = dec({8'h00, m});
    yi = dec(y);
    if (mi < 1 || mi > 12) return 0;
    if (di < 1 || di > days_in(mi, yi)) return 0;
    if (w > 3'd6) return 0;
    return 1;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic chk_date(string n, logic [7:0] d, logic [7:0] m,
                          logic [15:0] y);
    chk({n, "_day"}, {24'h0, day_ten, day_unit}, {24'h0, d});
    chk({n, "_month"}, {24'h0, month_ten, month_unit}, {24'h0, m});
    chk({n, "_year"},
        {16'h0, year_thousand, year_hundered, year_ten, year_unit},
        {16'h0, y});
  endtask

  task automatic chk_pulse(string n, bit err, bit mr, bit yr, bit wr);
    chk({n, "_pulses"},
        {28'h0, set_err, month_roll, year_roll, wrap},
        {28'h0, err, mr, yr, wr});
  endtask

  // Calendar model in plain integers
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md <= 1; mm <= 1; my <= 2000; mw <= 6;
      e_err <= 0; e_mr <= 0; e_yr <= 0; e_wr <= 0;
    end else begin
      e_err <= 0; e_mr <= 0; e_yr <= 0; e_wr <= 0;
      if (set_valid) begin
        if (set_ok(set_day, set_month, set_year, w_in)) begin
          md <= dec({8'h00, set_day});
          mm <= dec({8'h00, set_month});
          my <= dec(set_year);
          mw <= int'(w_in);
        end else begin
          e_err <= 1;
        end
      end else if (day_tick) begin
        mw <= (mw + 1) % 7;
        if (md < days_in(mm, my)) begin
          md <= md + 1;
        end else begin
          md <= 1;
          e_mr <= 1;
          if (mm == 12) begin
            mm <= 1;
            e_yr <= 1;
            if (my == 9999) begin
              my <= 0;
              e_wr <= 1;
            end else begin
              my <= my + 1;
            end
          end else begin
            mm <= mm + 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk_date("model", bcd2(md), bcd2(mm), bcd4(my));
      chk_pulse("model", e_err, e_mr, e_yr, e_wr);
`ifdef DATE_COUNTER_WEEKDAY_EN
      chk("model_wday", {29'h0, wday}, 32'(mw));
`endif
    end
  end

  task automatic step(bit t, bit s, logic [7:0] d, logic [7:0] m,
                      logic [15:0] y);
    day_tick  = t;
    set_valid = s;
    set_day   = d;
    set_month = m;
    set_year  = y;
    @(posedge clk);
    #1;
    day_tick  = 1'b0;
    set_valid = 1'b0;
  endtask

  task automatic load(logic [7:0] d, logic [7:0] m, logic [15:0] y);
    step(1'b0, 1'b1, d, m, y);
  endtask

  task automatic tick();
    step(1'b1, 1'b0, 8'h00, 8'h00, 16'h0000);
  endtask

  logic [31:0] rej [5] = '{
    {8'h29, 8'h02, 16'h2023},
    {8'h31, 8'h04, 16'h2024},
    {8'h01, 8'h13, 16'h2024},
    {8'h00, 8'h05, 16'h2024},
    {8'h1A, 8'h05, 16'h2024}
  };

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk_date("reset", 8'h01, 8'h01, 16'h2000);
    chk_pulse("reset", 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    live = 1'b1;
`ifdef DATE_COUNTER_WEEKDAY_EN
    chk("reset_wday", {29'h0, wday}, 32'd6);
`endif

    load(8'h28, 8'h02, 16'h2024);
    chk_date("ld20240228", 8'h28, 8'h02, 16'h2024);
    chk_pulse("ld20240228", 0, 0, 0, 0);
    tick();
    chk_date("leap29", 8'h29, 8'h02, 16'h2024);
    tick();
    chk_date("leapmar", 8'h01, 8'h03, 16'h2024);
    chk_pulse("leapmar", 0, 1, 0, 0);

    load(8'h28, 8'h02, 16'h2100);
    tick();
    chk_date("c2100", 8'h01, 8'h03, 16'h2100);
    load(8'h29, 8'h02, 16'h2000);
    chk_date("c2000", 8'h29, 8'h02, 16'h2000);
    chk_pulse("c2000", 0, 0, 0, 0);

    load(8'h31, 8'h12, 16'h2023);
    tick();
    chk_date("newyear", 8'h01, 8'h01, 16'h2024);
    chk_pulse("newyear", 0, 1, 1, 0);
    load(8'h31, 8'h12, 16'h9999);
    tick();
    chk_date("wrap", 8'h01, 8'h01, 16'h0000);
    chk_pulse("wrap", 0, 1, 1, 1);

    foreach (rej[i]) begin
      load(rej[i][31:24], rej[i][23:16], rej[i][15:0]);
      chk_date("reject", 8'h01, 8'h01, 16'h0000);
      chk_pulse("reject", 1, 0, 0, 0);
    end
    step(1'b1, 1'b1, 8'h32, 8'h01, 16'h2024);
    chk_date("rej_tick", 8'h01, 8'h01, 16'h0000);
    chk_pulse("rej_tick", 1, 0, 0, 0);
`ifdef DATE_COUNTER_WEEKDAY_EN
    set_wday = 3'd7;
    load(8'h01, 8'h01, 16'h2024);
    chk_pulse("rej_wday", 1, 0, 0, 0);
    set_wday = 3'd0;
`endif

    load(8'h31, 8'h01, 16'h2025);
    step(1'b1, 1'b1, 8'h15, 8'h07, 16'h2025);
    chk_date("set_tick", 8'h15, 8'h07, 16'h2025);
    chk_pulse("set_tick", 0, 0, 0, 0);
    repeat (31) tick();
    chk_date("ticks31", 8'h15, 8'h08, 16'h2025);

    day_tick = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk_date("async_rst", 8'h01, 8'h01, 16'h2000);
    chk_pulse("async_rst", 0, 0, 0, 0);
    day_tick = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk_date("post_rst", 8'h02, 8'h01, 16'h2000);

    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
